// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int INST_BYTES = 4;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~(XLEN'(INST_BYTES - 1));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage, occupancy count and a flush
// that empties it on the next clock edge.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count != CW'(DEPTH));
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// Prefetching instruction fetch stage: credit-limited requests to memory,
// in-order response buffering, and redirect flush with in-flight drop counting.
module ifetch_prefetch
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] restart_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   inflight_next;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   credits;
  logic            req_fire;
  logic            rsp_fire;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Every outstanding request owns a FIFO slot, so the buffer can never overflow.
  assign credits       = CW'(DEPTH) - count - inflight;
  assign mem_req_valid = !rst && (credits != '0);
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rsp_fire      = mem_rsp_valid && (inflight != '0);
  assign push          = rsp_fire && (drop == '0) && !redirect_valid;
  assign inst_valid    = (count != '0);
  assign pop           = inst_valid && inst_ready;
  assign inflight_next = inflight + CW'(req_fire) - CW'(rsp_fire);
  assign restart_pc    = align_pc(redirect_pc);
  assign push_entry    = '{pc: rsp_pc, data: mem_rsp_data};
  assign inst_data     = head.data;
  assign inst_pc       = head.pc;

  sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  // On redirect, everything still outstanding (including this cycle's accept) is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_next;
      if (redirect_valid) begin
        fetch_pc <= restart_pc;
        rsp_pc   <= restart_pc;
        drop     <= inflight_next;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
        end
        if (push) begin
          rsp_pc <= rsp_pc + XLEN'(INST_BYTES);
        end
        if (rsp_fire && (drop != '0)) begin
          drop <= drop - CW'(1);
        end
      end
    end
  end

endmodule

// File: doc/ifetch_prefetch.md
# ifetch_prefetch

Instruction fetch front end placed directly upstream of the single-cycle core's instruction input. It issues word-aligned fetch requests to a ready/valid instruction memory port, buffers returned words with their PCs in a small FIFO, and presents them to the core over a valid/ready interface. A redirect input (taken branch/jump) flushes buffered and in-flight instructions and restarts fetch at the new PC.

## Interface
- XLEN, 32, address/data width
- DEPTH, 4, FIFO entries and max outstanding requests; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- mem_req_valid  out  1  fetch request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  XLEN  fetch address, bits [1:0] always 0
- mem_rsp_valid  in  1  response word valid; in order, ≥1 cycle after acceptance
- mem_rsp_data  in  XLEN  response instruction word
- inst_valid  out  1  inst_data/inst_pc valid
- inst_ready  in  1  core consumes instruction
- inst_data  out  XLEN  instruction word
- inst_pc  out  XLEN  PC of inst_data
- redirect_valid  in  1  flush and restart
- redirect_pc  in  XLEN  restart PC; bits [1:0] ignored (forced 0)

## Operation
- State: fetch_pc, rsp_pc, FIFO (count 0..DEPTH), inflight (0..DEPTH), drop (0..DEPTH); counters clog2(DEPTH)+1 bits.
- Credits = DEPTH − count − inflight (drop entries are part of inflight). mem_req_valid = (credits > 0); mem_req_addr = fetch_pc.
- Request handshake (valid & ready): inflight+1; fetch_pc += 4, wraps modulo 2^XLEN.
- Response: inflight−1. If drop > 0: drop−1, word discarded. Else push {rsp_pc, mem_rsp_data}, rsp_pc += 4.
- Pop: inst_valid & inst_ready removes FIFO head.
- Redirect (highest priority, same cycle): FIFO cleared; fetch_pc = rsp_pc = {redirect_pc[XLEN-1:2],2'b00}; drop = inflight after this cycle's request/response updates (request accepted in redirect cycle is dropped; response arriving in redirect cycle is discarded, not pushed); pop in same cycle is a no-op.
- Push and pop in same cycle with count==DEPTH cannot occur (credits prevent overflow); simultaneous push/pop keeps count.
- mem_rsp_valid while inflight==0: ignored, no state change.
- Mid-operation rst: all state returns to reset values immediately; responses to pre-reset requests are not filtered (memory must be reset alongside).

## Timing
- Reset values: mem_req_valid 0 while rst high, mem_req_addr RESET_PC, inst_valid 0, inst_data 0, inst_pc 0; fetch_pc = rsp_pc = RESET_PC, counters 0.
- mem_req_valid asserts in first cycle after rst deasserts (credits = DEPTH).
- Response at edge M → inst_valid at M+1 (no bypass); registered FIFO head outputs.
- Redirect sampled at edge R → inst_valid 0 and mem_req_addr = redirect_pc from R+1; first new instruction earliest R+3 with single-cycle memory (accept R+1, respond R+2).
- Sustained throughput 1 instr/cycle when memory returns every cycle and inst_ready high.
- Back-pressure: inst_ready low → FIFO fills, mem_req_valid drops once credits reach 0.

## Structure
- Package fetch_pkg: XLEN, INST_BYTES (4), NOP word 32'h0000_0013, fifo entry struct {pc, data}.
- One sub-module: sync_fifo (parameterised width/depth, count output, synchronous flush, async active-high rst); ifetch_prefetch holds counters, PC registers and credit logic.

## Test plan
- Reset release, mem_req_ready=1, memory responds next cycle with word = addr ^ 32'hA5A5_0000 → inst_pc 0,4,8,… in order, one per cycle, data matches.
- inst_ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests accepted, mem_req_valid 0 afterwards; on release 4 instructions drain then streaming resumes.
- Redirect to 32'h0000_0103 with 3 requests in flight → those 3 responses discarded, next inst_pc = 32'h0000_0100, mem_req_addr 32'h0000_0100 at R+1.
- Redirect in same cycle as response and request handshake → response not delivered, accepted request's response dropped, no stale PC appears.
- fetch_pc at 32'hFFFF_FFFC → next request address 32'h0000_0000.
- rst asserted while FIFO holds 3 entries → inst_valid 0 immediately, restart at RESET_PC.
